// File: rtl/regbank_32_out.sv
// Write-side register bank: four 32-bit sources streamed as an AHB-Lite write burst.
// Optional error abort on hresp is enabled by defining REGBANK_OUT_ERR_EN.
module regbank_32_out #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_en,
    input  logic [1:0]        ld_sel,
    input  logic [31:0]       ld_data,
    input  logic              start,
    input  logic [1:0]        sr1,
    input  logic [1:0]        cnt,
    input  logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [31:0]       hwdatax1,
    input  logic              hready,
    input  logic              hresp,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    state_t            state_q, state_d;
    logic [31:0]       regs_q [4];
    logic [31:0]       regs_d [4];
    logic [1:0]        beat_q, beat_d;
    logic [1:0]        sr1_q, sr1_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic [1:0]        htrans_q, htrans_d;
    logic              hwrite_q, hwrite_d;
    logic [2:0]        hburst_q, hburst_d;
    logic [31:0]       hwdata_q, hwdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [1:0]        beat_nxt;
    logic [1:0]        rd_idx;
    logic [1:0]        drain_idx;
    logic              abort;
    logic              err_hold;

`ifdef REGBANK_OUT_ERR_EN
    assign abort    = hresp & hready;
    assign err_hold = hresp & ~hready;
`else
    logic unused_hresp;
    assign unused_hresp = hresp;
    assign abort        = 1'b0;
    assign err_hold     = 1'b0;
`endif

    always_comb begin
        beat_nxt  = beat_q + 2'd1;
        rd_idx    = sr1_q + beat_q;
        drain_idx = sr1_q + cnt_q;

        for (int i = 0; i < 4; i++) begin
            regs_d[i] = regs_q[i];
        end
        // Source data is frozen while a transfer is in flight
        if (ld_en && !busy_q) begin
            regs_d[ld_sel] = ld_data;
        end

        state_d  = state_q;
        beat_d   = beat_q;
        sr1_d    = sr1_q;
        cnt_d    = cnt_q;
        base_d   = base_q;
        haddr_d  = haddr_q;
        htrans_d = htrans_q;
        hwrite_d = hwrite_q;
        hburst_d = hburst_q;
        hwdata_d = hwdata_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                htrans_d = HT_IDLE;
                hwrite_d = 1'b0;
                if (start) begin
                    state_d  = S_ADDR;
                    beat_d   = 2'd0;
                    sr1_d    = sr1;
                    cnt_d    = cnt;
                    base_d   = start_addr;
                    haddr_d  = start_addr;
                    htrans_d = HT_NONSEQ;
                    hwrite_d = 1'b1;
                    hburst_d = (cnt == 2'd0) ? 3'b000 : 3'b001;
                    busy_d   = 1'b1;
                end
            end
            S_ADDR: begin
                if (abort) begin
                    state_d  = S_IDLE;
                    htrans_d = HT_IDLE;
                    hwrite_d = 1'b0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    err_d    = 1'b1;
                end else if (hready) begin
                    if (beat_q == cnt_q) begin
                        state_d  = S_DRAIN;
                        htrans_d = HT_IDLE;
                        hwrite_d = 1'b0;
                        hwdata_d = regs_q[drain_idx];
                    end else begin
                        beat_d   = beat_nxt;
                        haddr_d  = base_q + {{(ADDR_W-4){1'b0}}, beat_nxt, 2'b00};
                        htrans_d = HT_SEQ;
                        hwrite_d = 1'b1;
                        hwdata_d = regs_q[rd_idx];
                    end
                end else if (err_hold) begin
                    // First cycle of a two-cycle ERROR: cancel the pending beat
                    htrans_d = HT_IDLE;
                    hwrite_d = 1'b0;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else if (hready) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= 32'h0;
            end
            beat_q   <= 2'd0;
            sr1_q    <= 2'd0;
            cnt_q    <= 2'd0;
            base_q   <= '0;
            haddr_q  <= '0;
            htrans_q <= HT_IDLE;
            hwrite_q <= 1'b0;
            hburst_q <= 3'b000;
            hwdata_q <= 32'h0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= regs_d[i];
            end
            beat_q   <= beat_d;
            sr1_q    <= sr1_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            haddr_q  <= haddr_d;
            htrans_q <= htrans_d;
            hwrite_q <= hwrite_d;
            hburst_q <= hburst_d;
            hwdata_q <= hwdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign haddr    = haddr_q;
    assign htrans   = htrans_q;
    assign hwrite   = hwrite_q;
    assign hsize    = 3'b010;
    assign hburst   = hburst_q;
    assign hwdatax1 = hwdata_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
